// File: rtl/esc_array.sv
// esc_array: N-channel ESC pulse generator with arming sequencer, per-frame speed update and saturation; define ESC_SLEW_EN to enable per-frame slew limiting
module esc_array #(
    parameter int NUM_CH      = 4,
    parameter int SPD_W       = 11,
    parameter int PERIOD_BITS = 20,
    parameter int MIN_PULSE   = 50000,
    parameter int MAX_PULSE   = 110000,
    parameter int OFFSET      = 'h220,
    parameter int SCALE_SH    = 4,
    parameter int ARM_FRAMES  = 64,
    parameter int SLEW_STEP   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*SPD_W-1:0] spd,
    input  logic                    motors_off,
    input  logic                    arm_req,
    output logic                    armed,
    output logic                    frame_strt,
    output logic [NUM_CH-1:0]       pwm
);
    localparam logic [1:0] S_DIS    = 2'd0;
    localparam logic [1:0] S_ARMING = 2'd1;
    localparam logic [1:0] S_ARMED  = 2'd2;
    localparam int AW = $clog2(ARM_FRAMES + 1);
    localparam int SUM_SH_W = SPD_W + 1 + SCALE_SH;
    // raw width is kept wide enough that a large speed cannot wrap below the clamp
    localparam int RW = ((SUM_SH_W > PERIOD_BITS) ? SUM_SH_W : PERIOD_BITS) + 1;

    if (MAX_PULSE >= (1 << PERIOD_BITS)) begin : g_bad_max
        $error("esc_array: MAX_PULSE must be below 2**PERIOD_BITS");
    end

    logic [PERIOD_BITS-1:0] r_cnt;
    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [AW-1:0]          r_arm_cnt;
    logic                   r_armed;
    logic                   r_frame_strt;
    logic [NUM_CH-1:0]      r_pwm;
    logic [SPD_W-1:0]       r_applied   [NUM_CH];
    logic [SPD_W-1:0]       w_applied_nxt [NUM_CH];
    logic [PERIOD_BITS-1:0] r_width     [NUM_CH];
    logic [PERIOD_BITS-1:0] w_width_nxt [NUM_CH];
    logic                   w_bnd;
    logic                   w_arm_done;

    assign w_bnd      = &r_cnt;
    assign w_arm_done = (r_arm_cnt == AW'(ARM_FRAMES - 1));
    assign armed      = r_armed;
    assign frame_strt = r_frame_strt;
    assign pwm        = r_pwm;

    // next arming state, only consumed at the frame boundary
    always_comb begin
        w_state_nxt = !arm_req ? S_DIS :
                      (r_state == S_DIS) ? S_ARMING :
                      (r_state == S_ARMING && w_arm_done) ? S_ARMED : r_state;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [SPD_W-1:0] w_tgt;
        logic [SPD_W-1:0] w_step;
        logic [SPD_W:0]   w_sum;
        logic [RW-1:0]    w_raw;
        assign w_tgt = spd[g*SPD_W +: SPD_W];
`ifdef ESC_SLEW_EN
        logic [SPD_W:0] w_up;
        logic [SPD_W:0] w_dn_lim;
        assign w_up     = {1'b0, r_applied[g]} + (SPD_W+1)'(SLEW_STEP);
        assign w_dn_lim = {1'b0, w_tgt} + (SPD_W+1)'(SLEW_STEP);
        assign w_step   = ({1'b0, w_tgt} > w_up) ? w_up[SPD_W-1:0] :
                          (w_dn_lim < {1'b0, r_applied[g]}) ? r_applied[g] - SPD_W'(SLEW_STEP) : w_tgt;
`else
        assign w_step = w_tgt;
`endif
        assign w_applied_nxt[g] = (w_state_nxt == S_ARMED) ? w_step : '0;
        assign w_sum = (w_state_nxt == S_ARMED && !motors_off) ?
                       {1'b0, w_applied_nxt[g]} + (SPD_W+1)'(OFFSET) : '0;
        assign w_raw = RW'(MIN_PULSE) + (RW'(w_sum) << SCALE_SH);
        assign w_width_nxt[g] = (w_raw > RW'(MAX_PULSE)) ? PERIOD_BITS'(MAX_PULSE) : w_raw[PERIOD_BITS-1:0];
    end

    // frame counter, sequencer and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_state      <= S_DIS;
            r_arm_cnt    <= '0;
            r_armed      <= 1'b0;
            r_frame_strt <= 1'b0;
        end else begin
            r_cnt        <= r_cnt + 1'b1;
            r_armed      <= (r_state == S_ARMED);
            r_frame_strt <= (r_cnt == '0);
            if (w_bnd) begin
                r_state   <= w_state_nxt;
                r_arm_cnt <= (r_state == S_ARMING && w_state_nxt == S_ARMING) ? r_arm_cnt + 1'b1 : '0;
            end
        end
    end

    // per-channel applied speed, latched width and pulse output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_applied[i] <= '0;
                r_width[i]   <= PERIOD_BITS'(MIN_PULSE);
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_pwm[i] <= (r_state != S_DIS) && (r_cnt < r_width[i]);
                if (w_bnd) begin
                    r_applied[i] <= w_applied_nxt[i];
                    r_width[i]   <= w_width_nxt[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_esc_array.sv
// tb_esc_array: directed frame-by-frame pulse width checks for esc_array
module tb_esc_array;
    localparam int NC = 4;
    localparam int SW = 11;
    localparam int FRAME = 1024;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NC*SW-1:0] spd = '0;
    logic             motors_off = 1'b0;
    logic             arm_req = 1'b0;
    logic             armed;
    logic             frame_strt;
    logic [NC-1:0]    pwm;

    int checks = 0;
    int errors = 0;
    int w [NC];
    int armed_at_start;
    int exp_ramp [4];

    always #5 clk = ~clk;

    esc_array #(
        .NUM_CH(NC), .SPD_W(SW), .PERIOD_BITS(10), .MIN_PULSE(100), .MAX_PULSE(1000),
        .OFFSET(16), .SCALE_SH(0), .ARM_FRAMES(2), .SLEW_STEP(64)
    ) dut (
        .clk(clk), .rst(rst), .spd(spd), .motors_off(motors_off), .arm_req(arm_req),
        .armed(armed), .frame_strt(frame_strt), .pwm(pwm)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic sync_frame();
        int n = 0;
        while (frame_strt !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_seen", int'(frame_strt), 1);
    endtask

    task automatic measure();
        sync_frame();
        armed_at_start = int'(armed);
        for (int c = 0; c < NC; c++) w[c] = 0;
        for (int k = 0; k < FRAME; k++) begin
            for (int c = 0; c < NC; c++) w[c] += int'(pwm[c]);
            @(negedge clk);
        end
    endtask

    task automatic chk_all(input string tag, input int exp);
        for (int c = 0; c < NC; c++) chk($sformatf("%s_ch%0d", tag, c), w[c], exp);
    endtask

    initial begin
        #1;
        chk("rst_pwm", int'(pwm), 0);
        chk("rst_armed", int'(armed), 0);
        chk("rst_fs", int'(frame_strt), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        measure();
        chk_all("disarmed", 0);
        chk("disarmed_armed", armed_at_start, 0);
        chk("period", int'(frame_strt), 1);
        sync_frame();
        arm_req = 1'b1;
        measure();
        chk_all("arm_req_frame", 0);
        measure();
        chk_all("arming1", 100);
        chk("arming1_armed", armed_at_start, 0);
        measure();
        chk_all("arming2", 100);
        chk("arming2_armed", armed_at_start, 0);
        sync_frame();
        spd[0 +: SW] = 11'd200;
        measure();
        chk_all("armed_first", 116);
        chk("armed_first_armed", armed_at_start, 1);
`ifdef ESC_SLEW_EN
        exp_ramp = '{180, 244, 308, 316};
`else
        exp_ramp = '{316, 316, 316, 316};
`endif
        for (int f = 0; f < 4; f++) begin
            measure();
            chk($sformatf("ramp%0d_ch0", f), w[0], exp_ramp[f]);
            chk($sformatf("ramp%0d_ch1", f), w[1], 116);
        end
        sync_frame();
        spd[0 +: SW] = 11'd2047;
        measure();
        chk("max_inprog_ch0", w[0], 316);
        measure();
`ifdef ESC_SLEW_EN
        chk("max_step_ch0", w[0], 380);
        repeat (9) measure();
        measure();
`endif
        chk("clamp_ch0", w[0], 1000);
        chk("clamp_ch3", w[3], 116);
        sync_frame();
        motors_off = 1'b1;
        measure();
        chk("moff_inprog_ch0", w[0], 1000);
        measure();
        chk_all("moff", 100);
        chk("moff_armed", armed_at_start, 1);
        sync_frame();
        arm_req = 1'b0;
        measure();
        chk_all("disarm_last", 100);
        chk("disarm_last_armed", armed_at_start, 1);
        measure();
        chk_all("disarm_after", 0);
        chk("disarm_after_armed", armed_at_start, 0);
        sync_frame();
        arm_req = 1'b1;
        measure();
        chk_all("rearm_req", 0);
        sync_frame();
        repeat (50) @(negedge clk);
        chk("prerst_pwm", int'(pwm), 15);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_pwm", int'(pwm), 0);
        chk("async_rst_armed", int'(armed), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
